// File: rtl/latch_gate_arbiter.sv
// Round-robin arbiter sharing one level-sensitive latch between requesters.
// Sequences the latch gate as setup, open, then close/hold around captured data.
module latch_gate_arbiter #(
  parameter int NREQ        = 4,
  parameter int WIDTH       = 4,
  parameter int GATE_CYCLES = 1,
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int CW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] din,
  output logic [NREQ-1:0]       gnt,
  output logic [IW-1:0]         owner,
  output logic                  latch_en,
  output logic [WIDTH-1:0]      latch_d,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    OPEN,
    CLOSE
  } state_t;

  state_t           state, state_n;
  logic [IW-1:0]    ptr, ptr_n;
  logic [IW-1:0]    owner_n;
  logic [WIDTH-1:0] d_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             hit;
  int               win;
  int               j;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      ptr     <= '0;
      owner   <= '0;
      latch_d <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      owner   <= owner_n;
      latch_d <= d_n;
      cnt     <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    owner_n = owner;
    d_n     = latch_d;
    cnt_n   = cnt;
    hit     = 1'b0;
    win     = 0;
    j       = 0;
    // Scan downward so the lowest offset from ptr wins.
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (req[j]) begin
        win = j;
        hit = 1'b1;
      end
    end
    unique case (state)
      IDLE: begin
        if (hit) begin
          state_n = SETUP;
          owner_n = IW'(win);
          d_n     = din[win*WIDTH +: WIDTH];
        end
      end
      SETUP: begin
        state_n = OPEN;
        cnt_n   = '0;
      end
      OPEN: begin
        if (cnt == CW'(GATE_CYCLES - 1))
          state_n = CLOSE;
        else
          cnt_n = cnt + 1'b1;
      end
      CLOSE: begin
        state_n = IDLE;
        ptr_n   = (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy     = (state != IDLE);
  assign latch_en = (state == OPEN);
  assign done     = (state == CLOSE);
  assign gnt      = busy ? (NREQ'(1) << owner) : '0;

endmodule

// File: tb/tb_latch_gate_arbiter.sv
// Directed bench: per-cycle vector table on a GATE_CYCLES=1 instance,
// hand sequences for open-window timing and mid-OPEN reset on GATE_CYCLES=3.
module tb_latch_gate_arbiter;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [15:0] din;
    logic [3:0]  gnt;
    logic [1:0]  own;
    logic        len;
    logic [3:0]  d;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t v[$];
  int   tests = 0;
  int   fails = 0;
  logic live  = 1'b0;

  logic        clk;
  logic        rst1, rst3;
  logic [3:0]  req1, req3;
  logic [15:0] din1, din3;
  logic [3:0]  gnt1, gnt3;
  logic [1:0]  own1, own3;
  logic        len1, len3;
  logic [3:0]  ld1, ld3;
  logic        busy1, busy3;
  logic        done1, done3;

  latch_gate_arbiter #(.NREQ(4), .WIDTH(4), .GATE_CYCLES(1)) u1 (
    .clk(clk), .reset(rst1), .req(req1), .din(din1),
    .gnt(gnt1), .owner(own1), .latch_en(len1),
    .latch_d(ld1), .busy(busy1), .done(done1)
  );

  latch_gate_arbiter #(.NREQ(4), .WIDTH(4), .GATE_CYCLES(3)) u3 (
    .clk(clk), .reset(rst3), .req(req3), .din(din3),
    .gnt(gnt3), .owner(own3), .latch_en(len3),
    .latch_d(ld3), .busy(busy3), .done(done3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string nm, int idx, logic [15:0] a, logic [15:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s @%0d: got %h expected %h", nm, idx, a, e);
    end
  endtask

  function automatic void add(logic r, logic [3:0] rq, logic [15:0] dn,
                              logic [3:0] g, logic [1:0] o, logic le,
                              logic [3:0] d, logic b, logic dd);
    v.push_back('{r, rq, dn, g, o, le, d, b, dd});
  endfunction

  // One full GATE_CYCLES=1 transaction: SETUP, OPEN, CLOSE, IDLE.
  function automatic void txn(logic [3:0] rq, logic [15:0] dn,
                              logic [1:0] o, logic [3:0] d);
    logic [3:0] g;
    g = 4'b0001 << o;
    add(1'b0, rq, dn, g, o, 1'b0, d, 1'b1, 1'b0);
    add(1'b0, rq, dn, g, o, 1'b1, d, 1'b1, 1'b0);
    add(1'b0, rq, dn, g, o, 1'b0, d, 1'b1, 1'b1);
    add(1'b0, rq, dn, 4'h0, o, 1'b0, d, 1'b0, 1'b0);
  endfunction

  // Invariants on both instances, sampled mid-cycle.
  logic       pb1, pb3;
  logic [3:0] pd1, pd3;
  always @(negedge clk) begin
    if (live) begin
      chk("inv1_onehot", 0, 16'($onehot0(gnt1)), 16'd1);
      chk("inv1_en_busy", 0, 16'(len1 & ~busy1), 16'd0);
      chk("inv1_en_edge", 0, 16'(len1 & (~pb1 | done1)), 16'd0);
      chk("inv1_d_stable", 0, 16'((busy1 & pb1) ? ld1 : pd1), 16'(pd1));
      chk("inv3_onehot", 0, 16'($onehot0(gnt3)), 16'd1);
      chk("inv3_en_busy", 0, 16'(len3 & ~busy3), 16'd0);
      chk("inv3_en_edge", 0, 16'(len3 & (~pb3 | done3)), 16'd0);
      chk("inv3_d_stable", 0, 16'((busy3 & pb3) ? ld3 : pd3), 16'(pd3));
    end
    pb1 <= busy1;
    pd1 <= ld1;
    pb3 <= busy3;
    pd3 <= ld3;
  end

  task automatic out3(string nm, int k, logic [3:0] g, logic [1:0] o,
                      logic le, logic [3:0] d, logic b, logic dd);
    chk({nm, "_gnt"}, k, 16'(gnt3), 16'(g));
    chk({nm, "_own"}, k, 16'(own3), 16'(o));
    chk({nm, "_en"}, k, 16'(len3), 16'(le));
    chk({nm, "_d"}, k, 16'(ld3), 16'(d));
    chk({nm, "_busy"}, k, 16'(busy3), 16'(b));
    chk({nm, "_done"}, k, 16'(done3), 16'(dd));
  endtask

  initial begin
    logic le, b, dd;
    rst1 = 1'b1; req1 = '0; din1 = '0;
    rst3 = 1'b1; req3 = '0; din3 = '0;

    // Single requester, latch_d held one extra IDLE cycle.
    add(1'b1, 4'h0, 16'h0000, 4'h0, 2'd0, 1'b0, 4'h0, 1'b0, 1'b0);
    add(1'b0, 4'b0010, 16'h00A0, 4'b0010, 2'd1, 1'b0, 4'hA, 1'b1, 1'b0);
    add(1'b0, 4'b0000, 16'h00A0, 4'b0010, 2'd1, 1'b1, 4'hA, 1'b1, 1'b0);
    add(1'b0, 4'b0000, 16'h00A0, 4'b0010, 2'd1, 1'b0, 4'hA, 1'b1, 1'b1);
    add(1'b0, 4'b0000, 16'h00A0, 4'h0, 2'd1, 1'b0, 4'hA, 1'b0, 1'b0);
    add(1'b0, 4'b0000, 16'h00A0, 4'h0, 2'd1, 1'b0, 4'hA, 1'b0, 1'b0);
    // Reset beats a pending request; then all four in ptr order.
    add(1'b1, 4'hF, 16'h4321, 4'h0, 2'd0, 1'b0, 4'h0, 1'b0, 1'b0);
    txn(4'hF, 16'h4321, 2'd0, 4'h1);
    txn(4'hF, 16'h4321, 2'd1, 4'h2);
    txn(4'hF, 16'h4321, 2'd2, 4'h3);
    txn(4'hF, 16'h4321, 2'd3, 4'h4);
    txn(4'hF, 16'h4321, 2'd0, 4'h1);
    // Requesters 0 and 3 alternate.
    add(1'b1, 4'b1001, 16'h7008, 4'h0, 2'd0, 1'b0, 4'h0, 1'b0, 1'b0);
    txn(4'b1001, 16'h7008, 2'd0, 4'h8);
    txn(4'b1001, 16'h7008, 2'd3, 4'h7);
    txn(4'b1001, 16'h7008, 2'd0, 4'h8);
    txn(4'b1001, 16'h7008, 2'd3, 4'h7);
    // ptr wrapped to 0; din changes in SETUP, req drops in OPEN.
    add(1'b0, 4'b0001, 16'h0005, 4'b0001, 2'd0, 1'b0, 4'h5, 1'b1, 1'b0);
    add(1'b0, 4'b0001, 16'h0009, 4'b0001, 2'd0, 1'b1, 4'h5, 1'b1, 1'b0);
    add(1'b0, 4'b0000, 16'h0009, 4'b0001, 2'd0, 1'b0, 4'h5, 1'b1, 1'b1);
    add(1'b0, 4'b0000, 16'h0009, 4'h0, 2'd0, 1'b0, 4'h5, 1'b0, 1'b0);
    add(1'b0, 4'b0000, 16'h0009, 4'h0, 2'd0, 1'b0, 4'h5, 1'b0, 1'b0);

    @(posedge clk);
    #1 live = 1'b1;
    for (int i = 0; i < v.size(); i++) begin
      rst1 = v[i].rst;
      req1 = v[i].req;
      din1 = v[i].din;
      @(posedge clk);
      #1;
      chk("vec_gnt", i, 16'(gnt1), 16'(v[i].gnt));
      chk("vec_own", i, 16'(own1), 16'(v[i].own));
      chk("vec_en", i, 16'(len1), 16'(v[i].len));
      chk("vec_d", i, 16'(ld1), 16'(v[i].d));
      chk("vec_busy", i, 16'(busy1), 16'(v[i].busy));
      chk("vec_done", i, 16'(done1), 16'(v[i].done));
    end

    // GATE_CYCLES=3 window: req at edge t.
    rst3 = 1'b0;
    @(posedge clk);
    #1 out3("g3_idle", 0, 4'h0, 2'd0, 1'b0, 4'h0, 1'b0, 1'b0);
    req3 = 4'b0100;
    din3 = 16'h0C00;
    for (int k = 0; k <= 5; k++) begin
      @(posedge clk);
      #1 req3 = 4'b0000;
      le = (k >= 1 && k <= 3);
      dd = (k == 4);
      b  = (k <= 4);
      out3("g3_time", k, b ? 4'b0100 : 4'h0, 2'd2, le, 4'hC, b, dd);
    end

    // ptr is now 3; winner 2 again, then reset in the 2nd OPEN cycle.
    req3 = 4'b0100;
    din3 = 16'h0600;
    @(posedge clk);
    #1 req3 = 4'b0000;
    out3("rst_setup", 0, 4'b0100, 2'd2, 1'b0, 4'h6, 1'b1, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 out3("rst_open2", 0, 4'b0100, 2'd2, 1'b1, 4'h6, 1'b1, 1'b0);
    rst3 = 1'b1;
    @(posedge clk);
    #1 out3("rst_clear", 0, 4'h0, 2'd0, 1'b0, 4'h0, 1'b0, 1'b0);
    // Fresh ptr=0 picks requester 1 over 3.
    rst3 = 1'b0;
    req3 = 4'b1010;
    din3 = 16'hB0D0;
    @(posedge clk);
    #1 req3 = 4'b0000;
    out3("rst_regrant", 0, 4'b0010, 2'd1, 1'b0, 4'hD, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) @(posedge clk);
    #1 out3("rst_end", 0, 4'h0, 2'd1, 1'b0, 4'hD, 1'b0, 1'b0);

    @(negedge clk);
    live = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
